// File: rtl/multiword_adder_ctrl_if.sv
// Link between the multiword sequencer and the single-word combinational adder it drives.
// master = sequencer side (drives operands), slave = adder side (returns sum and carry).
interface multiword_adder_ctrl_if #(
  parameter int BW_DATA = 8
);
  logic [BW_DATA-1:0] a;
  logic [BW_DATA-1:0] b;
  logic               ci;
  logic [BW_DATA-1:0] s;
  logic               co;

  modport master (output a, b, ci, input s, co);
  modport slave  (input a, b, ci, output s, co);
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Wide adder sequencer: feeds a BW_DATA-bit adder one word per cycle (LSW first),
// chaining the registered carry, to add two N_WORD*BW_DATA-bit operands.
module multiword_adder_ctrl #(
  parameter int BW_DATA = 8,
  parameter int N_WORD  = 4,
  localparam int BW_W   = BW_DATA * N_WORD
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [BW_W-1:0]         i_a,
  input  logic [BW_W-1:0]         i_b,
  input  logic                    i_c,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BW_W-1:0]         o_s,
  output logic                    o_c,
  output logic [1:0]              o_state,
  multiword_adder_ctrl_if.master  add_if
);

  // Handshake: i_start is a request sampled on the rising edge only while the
  // sequencer is IDLE or DONE (o_busy=0); o_done is a one-cycle result-valid pulse.

  localparam int CW = (N_WORD > 1) ? $clog2(N_WORD) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          r_state;
  logic [CW-1:0]                   r_cnt;
  logic [N_WORD-1:0][BW_DATA-1:0]  r_a;
  logic [N_WORD-1:0][BW_DATA-1:0]  r_b;
  logic [N_WORD-1:0][BW_DATA-1:0]  r_s;
  logic                            r_carry;
  logic                            r_c;
  logic                            r_busy;
  logic                            r_done;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_c;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_s[r_cnt] <= add_if.s;
          r_carry    <= add_if.co;
          if (r_cnt == LAST) begin
            // Counter parks on the last word instead of wrapping.
            r_c     <= add_if.co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    add_if.a  = '0;
    add_if.b  = '0;
    add_if.ci = 1'b0;
    if (r_state == RUN) begin
      add_if.a  = r_a[r_cnt];
      add_if.b  = r_b[r_cnt];
      add_if.ci = r_carry;
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_s     = r_s;
  assign o_c     = r_c;
  assign o_state = r_state;

endmodule
